// File: rtl/mem_ctrl.sv
// Byte-wide RAM bus controller: arbitrates ICache fetches and MEM loads/stores (MEM first),
// sequences one byte per cycle and returns little-endian assembled data with a done pulse.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ic_req_in,
  input  logic [31:0] ic_addr_in,
  output logic        ic_inst_valid_out,
  output logic [31:0] ic_inst_out,
  output logic        ic_busy_out,
  input  logic        mem_req_in,
  input  logic        mem_wr_in,
  input  logic [1:0]  mem_size_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  output logic        mem_busy_out,
  input  logic [7:0]  ram_din_in,
  output logic [7:0]  ram_dout_out,
  output logic [31:0] ram_addr_out,
  output logic        ram_wr_out
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IC_RD  = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_e;

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  function automatic logic [CW-1:0] len_of(input logic [1:0] size);
    case (size)
      2'b00:   len_of = CW'(1);
      2'b01:   len_of = CW'(2);
      default: len_of = CW'(4);
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  req_t          cur_q, cur_d;
  logic [DW-1:0] asm_q, asm_d;
  logic          ic_pv_q, ic_pv_d;
  req_t          ic_pr_q, ic_pr_d;
  logic          mem_pv_q, mem_pv_d;
  req_t          mem_pr_q, mem_pr_d;

  logic          ic_valid_q, ic_valid_d;
  logic [DW-1:0] ic_inst_q, ic_inst_d;
  logic          ic_busy_q, ic_busy_d;
  logic          mem_done_q, mem_done_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          mem_busy_q, mem_busy_d;
  logic [BW-1:0] ram_dout_q, ram_dout_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_wr_q, ram_wr_d;

  req_t          live_mem_c, live_ic_c, start_req_c;
  logic          start_c, start_ic_c;
  logic          fin_ic_c, fin_mem_rd_c, fin_mem_wr_c;
  logic [1:0]    rd_bidx_c;
  logic          xfer_c;

  assign live_mem_c = {mem_wr_in, mem_size_in, mem_addr_in, mem_wdata_in};
  assign live_ic_c  = {1'b0, 2'b10, ic_addr_in, 32'd0};
  // Byte arriving this cycle belongs to the address issued one cycle earlier.
  assign rd_bidx_c  = 2'(cnt_q - CW'(1));

  // State and output registers; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      cur_q       <= '0;
      asm_q       <= '0;
      ic_pv_q     <= 1'b0;
      ic_pr_q     <= '0;
      mem_pv_q    <= 1'b0;
      mem_pr_q    <= '0;
      ic_valid_q  <= 1'b0;
      ic_inst_q   <= '0;
      ic_busy_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_busy_q  <= 1'b0;
      ram_dout_q  <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cur_q       <= cur_d;
      asm_q       <= asm_d;
      ic_pv_q     <= ic_pv_d;
      ic_pr_q     <= ic_pr_d;
      mem_pv_q    <= mem_pv_d;
      mem_pr_q    <= mem_pr_d;
      ic_valid_q  <= ic_valid_d;
      ic_inst_q   <= ic_inst_d;
      ic_busy_q   <= ic_busy_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_busy_q  <= mem_busy_d;
      ram_dout_q  <= ram_dout_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  // Next state: arbitration, pending slots and byte sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    cur_d        = cur_q;
    asm_d        = asm_q;
    ic_pv_d      = ic_pv_q;
    ic_pr_d      = ic_pr_q;
    mem_pv_d     = mem_pv_q;
    mem_pr_d     = mem_pr_q;
    start_c      = 1'b0;
    start_ic_c   = 1'b0;
    start_req_c  = '0;
    fin_ic_c     = 1'b0;
    fin_mem_rd_c = 1'b0;
    fin_mem_wr_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_pv_q) begin
          start_c     = 1'b1;
          start_req_c = mem_pr_q;
          mem_pv_d    = mem_req_in;
          if (mem_req_in) mem_pr_d = live_mem_c;
        end else if (mem_req_in) begin
          start_c     = 1'b1;
          start_req_c = live_mem_c;
        end else if (ic_pv_q) begin
          start_c     = 1'b1;
          start_ic_c  = 1'b1;
          start_req_c = ic_pr_q;
          ic_pv_d     = 1'b0;
        end else if (ic_req_in && !ic_valid_q) begin
          start_c     = 1'b1;
          start_ic_c  = 1'b1;
          start_req_c = live_ic_c;
        end
        // A live fetch that loses to MEM waits; a repeat of an already pending fetch merges.
        if (!start_ic_c && ic_req_in && !ic_valid_q && !ic_pv_q) begin
          ic_pv_d = 1'b1;
          ic_pr_d = live_ic_c;
        end
      end
      S_IC_RD: begin
        if (mem_req_in) begin
          mem_pv_d = 1'b1;
          mem_pr_d = live_mem_c;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        if (ic_req_in) begin
          ic_pv_d = 1'b1;
          ic_pr_d = live_ic_c;
        end
      end
      default: ;
    endcase

    if (state_q == S_IC_RD || state_q == S_MEM_RD) begin
      if (cnt_q != '0) asm_d[{rd_bidx_c, 3'b000} +: BW] = ram_din_in;
      if (cnt_q == len_q) begin
        state_d      = S_IDLE;
        cnt_d        = '0;
        fin_ic_c     = (state_q == S_IC_RD);
        fin_mem_rd_c = (state_q == S_MEM_RD);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (state_q == S_MEM_WR) begin
      if (cnt_q + CW'(1) == len_q) begin
        state_d      = S_IDLE;
        cnt_d        = '0;
        fin_mem_wr_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (start_c) begin
      state_d = start_ic_c ? S_IC_RD : (start_req_c.wr ? S_MEM_WR : S_MEM_RD);
      cnt_d   = '0;
      len_d   = len_of(start_req_c.size);
      cur_d   = start_req_c;
      asm_d   = '0;
    end
  end

  // Outputs for next cycle, derived from the next state.
  always_comb begin
    xfer_c      = (state_d != S_IDLE) && (cnt_d < len_d);
    ram_wr_d    = xfer_c && (state_d == S_MEM_WR);
    ram_addr_d  = xfer_c ? cur_d.addr + AW'(cnt_d) : '0;
    ram_dout_d  = ram_wr_d ? cur_d.wdata[{cnt_d[1:0], 3'b000} +: BW] : '0;
    ic_valid_d  = fin_ic_c;
    ic_inst_d   = fin_ic_c ? asm_d : ic_inst_q;
    mem_done_d  = fin_mem_rd_c | fin_mem_wr_c;
    mem_rdata_d = fin_mem_rd_c ? asm_d : mem_rdata_q;
    ic_busy_d   = (state_d == S_IC_RD);
    mem_busy_d  = (state_d == S_MEM_RD) || (state_d == S_MEM_WR) || mem_pv_d;
  end

  assign ic_inst_valid_out = ic_valid_q;
  assign ic_inst_out       = ic_inst_q;
  assign ic_busy_out       = ic_busy_q;
  assign mem_done_out      = mem_done_q;
  assign mem_rdata_out     = mem_rdata_q;
  assign mem_busy_out      = mem_busy_q;
  assign ram_dout_out      = ram_dout_q;
  assign ram_addr_out      = ram_addr_q;
  assign ram_wr_out        = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a transaction-schedule model builds the expected per-cycle bus and
// client outputs (indexed by rdy-qualified cycle count); literal checks pin the model.
module tb_mem_ctrl;

  localparam int MAXC = 1023;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        ic_req_in;
  logic [31:0] ic_addr_in;
  logic        ic_inst_valid_out;
  logic [31:0] ic_inst_out;
  logic        ic_busy_out;
  logic        mem_req_in, mem_wr_in;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_addr_in, mem_wdata_in;
  logic        mem_done_out;
  logic [31:0] mem_rdata_out;
  logic        mem_busy_out;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_addr_out;
  logic        ram_wr_out;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req_in(ic_req_in), .ic_addr_in(ic_addr_in),
    .ic_inst_valid_out(ic_inst_valid_out), .ic_inst_out(ic_inst_out), .ic_busy_out(ic_busy_out),
    .mem_req_in(mem_req_in), .mem_wr_in(mem_wr_in), .mem_size_in(mem_size_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
    .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out), .mem_busy_out(mem_busy_out),
    .ram_din_in(ram_din), .ram_dout_out(ram_dout_out), .ram_addr_out(ram_addr_out),
    .ram_wr_out(ram_wr_out)
  );

  initial forever #5 clk_in = ~clk_in;

  logic [7:0]  ram [0:65535];
  logic [7:0]  mdl [0:65535];
  logic [31:0] e_addr  [0:MAXC];
  logic [7:0]  e_dout  [0:MAXC];
  logic        e_wr    [0:MAXC];
  logic        e_icv   [0:MAXC];
  logic        e_icb   [0:MAXC];
  logic        e_md    [0:MAXC];
  logic        e_mb    [0:MAXC];
  logic [31:0] e_inst  [0:MAXC];
  logic [31:0] e_rdata [0:MAXC];

  int t = 0;
  int idle_at = 0;
  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // RAM stalls with the controller when rdy_in is low.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (ram_wr_out) ram[ram_addr_out[15:0]] <= ram_dout_out;
      ram_din <= ram[ram_addr_out[15:0]];
    end
  end

  always @(posedge clk_in) if (rdy_in) t <= t + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (cmp_en && t <= MAXC) begin
      chk("ram_addr",  ram_addr_out,      e_addr[t]);
      chk("ram_wr",    ram_wr_out,        e_wr[t]);
      chk("ram_dout",  ram_dout_out,      e_dout[t]);
      chk("ic_valid",  ic_inst_valid_out, e_icv[t]);
      chk("ic_inst",   ic_inst_out,       e_inst[t]);
      chk("ic_busy",   ic_busy_out,       e_icb[t]);
      chk("mem_done",  mem_done_out,      e_md[t]);
      chk("mem_rdata", mem_rdata_out,     e_rdata[t]);
      chk("mem_busy",  mem_busy_out,      e_mb[t]);
    end
  end

  function automatic int start_of(input int c);
    return (c > idle_at) ? c : idle_at;
  endfunction

  // Read of n bytes requested in cycle c: addresses s+1..s+n, completion at s+n+2.
  task automatic model_read(input int c, input logic [31:0] addr, input int n, input bit is_ic);
    int s, v;
    logic [31:0] a, d;
    s = start_of(c);
    d = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      e_addr[s+1+i] = a;
      d[8*i +: 8] = mdl[a[15:0]];
    end
    v = s + n + 2;
    if (is_ic) begin
      e_icv[v] = 1'b1;
      for (int k = v; k <= MAXC; k++) e_inst[k] = d;
      for (int k = s + 1; k < v; k++) e_icb[k] = 1'b1;
    end else begin
      e_md[v] = 1'b1;
      for (int k = v; k <= MAXC; k++) e_rdata[k] = d;
      for (int k = c + 1; k < v; k++) e_mb[k] = 1'b1;
    end
    idle_at = v;
  endtask

  // Store of n bytes requested in cycle c: writes s+1..s+n, done at s+n+1.
  task automatic model_write(input int c, input logic [31:0] addr, input int n, input logic [31:0] data);
    int s, v;
    logic [31:0] a;
    s = start_of(c);
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      e_addr[s+1+i] = a;
      e_wr[s+1+i]   = 1'b1;
      e_dout[s+1+i] = data[8*i +: 8];
      mdl[a[15:0]]  = data[8*i +: 8];
    end
    v = s + n + 1;
    e_md[v] = 1'b1;
    for (int k = c + 1; k < v; k++) e_mb[k] = 1'b1;
    idle_at = v;
  endtask

  task automatic model_reset(input int r);
    for (int k = r + 1; k <= MAXC; k++) begin
      e_addr[k] = '0; e_dout[k] = '0; e_wr[k] = 1'b0; e_icv[k] = 1'b0; e_icb[k] = 1'b0;
      e_md[k] = 1'b0; e_mb[k] = 1'b0; e_inst[k] = '0; e_rdata[k] = '0;
    end
    idle_at = r + 1;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] b);
    ram[a] = b;
    mdl[a] = b;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    model_reset(t);
    tick();
    rst_in = 1'b0;
  endtask

  task automatic ic_req(input logic [31:0] addr);
    ic_req_in  = 1'b1;
    ic_addr_in = addr;
    model_read(t, addr, 4, 1'b1);
    tick();
    ic_req_in = 1'b0;
  endtask

  task automatic mem_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int n;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mem_req_in   = 1'b1;
    mem_wr_in    = wr;
    mem_size_in  = size;
    mem_addr_in  = addr;
    mem_wdata_in = wdata;
    if (wr) model_write(t, addr, n, wdata);
    else    model_read(t, addr, n, 1'b0);
    tick();
    mem_req_in = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) begin ram[k] = 8'h00; mdl[k] = 8'h00; end
    model_reset(-1);
    rst_in = 1'b1; rdy_in = 1'b1; ic_req_in = 1'b0; ic_addr_in = '0;
    mem_req_in = 1'b0; mem_wr_in = 1'b0; mem_size_in = '0; mem_addr_in = '0; mem_wdata_in = '0;
    preload(16'h0104, 8'h13); preload(16'h0105, 8'h05);
    preload(16'h0106, 8'h00); preload(16'h0107, 8'h00);
    preload(16'h0108, 8'h93); preload(16'h0109, 8'h08);
    preload(16'h010A, 8'h10); preload(16'h010B, 8'h00);
    preload(16'h2003, 8'h80);
    preload(16'h2010, 8'h34); preload(16'h2011, 8'h12);
    preload(16'h3000, 8'h11); preload(16'h3001, 8'h22);
    preload(16'h3002, 8'h33); preload(16'h3003, 8'h44);

    tick();
    do_reset();
    cmp_en = 1'b1;
    chk("rst_ram_addr", ram_addr_out, 32'h0);
    chk("rst_ram_wr", ram_wr_out, 32'h0);
    chk("rst_ic_inst", ic_inst_out, 32'h0);
    chk("rst_mem_busy", mem_busy_out, 32'h0);
    ticks(2);

    // IC fetch of 0x104
    ic_req(32'h0000_0104);
    chk("fetch_busy_c1", ic_busy_out, 32'h1);
    ticks(4);
    chk("fetch_valid_c5", ic_inst_valid_out, 32'h0);
    tick();
    chk("fetch_valid_c6", ic_inst_valid_out, 32'h1);
    chk("fetch_inst_c6", ic_inst_out, 32'h0000_0513);
    ticks(3);

    // Word store
    mem_req(1'b1, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF);
    chk("st_wr_c1", ram_wr_out, 32'h1);
    chk("st_addr_c1", ram_addr_out, 32'h0000_1000);
    chk("st_dout_c1", ram_dout_out, 32'h0000_00EF);
    ticks(4);
    chk("st_done_c5", mem_done_out, 32'h1);
    tick();
    chk("st_ram_1003", ram[16'h1003], 32'h0000_00DE);
    ticks(2);

    // Byte and half loads
    mem_req(1'b0, 2'b00, 32'h0000_2003, 32'h0);
    ticks(2);
    chk("lb_done_c3", mem_done_out, 32'h1);
    chk("lb_rdata_c3", mem_rdata_out, 32'h0000_0080);
    ticks(2);
    mem_req(1'b0, 2'b01, 32'h0000_2010, 32'h0);
    ticks(3);
    chk("lh_done_c4", mem_done_out, 32'h1);
    chk("lh_rdata_c4", mem_rdata_out, 32'h0000_1234);
    ticks(2);

    // Simultaneous requests: MEM wins, IC held high and must fetch only once
    ic_req_in  = 1'b1;
    ic_addr_in = 32'h0000_0108;
    mem_req_in = 1'b1; mem_wr_in = 1'b0; mem_size_in = 2'b10;
    mem_addr_in = 32'h0000_3000; mem_wdata_in = '0;
    model_read(t, 32'h0000_3000, 4, 1'b0);
    model_read(t, 32'h0000_0108, 4, 1'b1);
    tick();
    mem_req_in = 1'b0;
    ticks(5);
    chk("sim_mem_done_c6", mem_done_out, 32'h1);
    chk("sim_mem_rdata_c6", mem_rdata_out, 32'h4433_2211);
    tick();
    chk("sim_ic_addr_c7", ram_addr_out, 32'h0000_0108);
    ticks(5);
    ic_req_in = 1'b0;
    chk("sim_ic_valid_c12", ic_inst_valid_out, 32'h1);
    chk("sim_ic_inst_c12", ic_inst_out, 32'h0010_0893);
    ticks(3);

    // MEM request (size 11) arriving during an IC fetch waits in its pending slot
    ic_req(32'h0000_0104);
    tick();
    mem_req(1'b0, 2'b11, 32'h0000_3000, 32'h0);
    chk("pend_busy_c3", mem_busy_out, 32'h1);
    ticks(3);
    chk("pend_ic_valid_c6", ic_inst_valid_out, 32'h1);
    ticks(6);
    chk("pend_done_c12", mem_done_out, 32'h1);
    chk("pend_rdata_c12", mem_rdata_out, 32'h4433_2211);
    ticks(2);

    // Reset in cycle 3 of a word store, then normal traffic
    mem_req(1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D);
    ticks(2);
    do_reset();
    chk("rst_mid_wr", ram_wr_out, 32'h0);
    chk("rst_mid_addr", ram_addr_out, 32'h0);
    chk("rst_mid_rdata", mem_rdata_out, 32'h0);
    chk("rst_mid_busy", mem_busy_out, 32'h0);
    tick();
    chk("rst_mid_nodone", mem_done_out, 32'h0);
    mem_req(1'b1, 2'b01, 32'h0000_5000, 32'h0000_A55A);
    ticks(2);
    chk("post_rst_st_done", mem_done_out, 32'h1);
    mem_req(1'b0, 2'b01, 32'h0000_5000, 32'h0);
    ticks(3);
    chk("post_rst_ld_rdata", mem_rdata_out, 32'h0000_A55A);
    ticks(2);

    // rdy_in low in cycles 2..4 of a fetch
    ic_req(32'h0000_0104);
    tick();
    rdy_in = 1'b0;
    ticks(3);
    rdy_in = 1'b1;
    tick();
    chk("stall_valid_c6", ic_inst_valid_out, 32'h0);
    ticks(3);
    chk("stall_valid_c9", ic_inst_valid_out, 32'h1);
    chk("stall_inst_c9", ic_inst_out, 32'h0000_0513);
    ticks(3);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the core's two memory clients (instruction cache fetch port, MEM-stage load/store port) and the byte-wide single-port RAM bus. It accepts single-cycle requests, arbitrates (MEM over ICache), sequences multi-byte accesses one byte per cycle, and returns assembled little-endian data with a one-cycle valid pulse. It is the responder end of the ICache miss-fill interface and drives the busy flags the ICache and MEM stage use to hold off.

## Interface
- No parameters. Transfer sizes are fixed: byte, half, word.
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous, active-high reset.
- `rdy_in` input 1: global ready. Low freezes all state.
- `ic_req_in` input 1: ICache fetch request pulse. Always a 4-byte read.
- `ic_addr_in` input 32: fetch address. Only [17:0] is significant.
- `ic_inst_valid_out` output 1: one-cycle pulse; the fetched word is on `ic_inst_out`.
- `ic_inst_out` output 32: fetched instruction, little-endian.
- `ic_busy_out` output 1: an ICache transaction is in flight.
- `mem_req_in` input 1: MEM request pulse.
- `mem_wr_in` input 1: 1 = store, 0 = load.
- `mem_size_in` input 2: 00 = byte, 01 = half, 10 = word. 11 is treated as word.
- `mem_addr_in` input 32: byte address.
- `mem_wdata_in` input 32: store data. Byte i of a store is bits [8i+7:8i].
- `mem_done_out` output 1: one-cycle pulse; load data valid or store complete.
- `mem_rdata_out` output 32: load data, zero-extended. Sign extension is done by MEM.
- `mem_busy_out` output 1: a MEM transaction is pending or in flight.
- `ram_din_in` input 8: RAM read byte. It is valid the cycle after its address was driven.
- `ram_dout_out` output 8: RAM write byte.
- `ram_addr_out` output 32: RAM byte address.
- `ram_wr_out` output 1: 1 = write this cycle.

## Operation
- States:
  - IDLE: no access in progress.
  - IC_RD: serving an ICache fetch.
  - MEM_RD: serving a load.
  - MEM_WR: serving a store.
- State registers:
  - byte counter `cnt`, 3 bits;
  - transfer length N, 1, 2 or 4;
  - a 32-bit assembly register;
  - one pending slot per client, holding the request fields.
- Acceptance in IDLE, sampled on the clock edge:
  - A pending MEM request is started first, then a live `mem_req_in`, then a pending IC request, then a live `ic_req_in`.
  - A request that is live but not started in the same cycle is stored in its pending slot.
- Requests while not IDLE:
  - `ic_req_in` is latched into the IC pending slot only when the current state is MEM_RD or MEM_WR.
  - During IC_RD, and in the cycle of `ic_inst_valid_out`, `ic_req_in` is ignored. This absorbs ICache re-requests during its own miss.
  - `mem_req_in` during a MEM transaction is a protocol violation and is ignored.
- Read sequence, N bytes:
  - For i = 0..N-1, `ram_addr_out` = addr+i with `ram_wr_out` = 0.
  - The byte returned the following cycle is placed into assembly bits [8i+7:8i].
  - After the last byte is captured, the client's data output is loaded and its valid/done pulse is raised for one cycle. The state returns to IDLE.
- Write sequence, N bytes:
  - For i = 0..N-1, `ram_wr_out` = 1, `ram_addr_out` = addr+i, `ram_dout_out` = byte i.
  - Then `mem_done_out` pulses and the state returns to IDLE.
- Address arithmetic is 32-bit with natural wrap. No alignment check is made.
- Busy flags:
  - `ic_busy_out` = (state == IC_RD).
  - `mem_busy_out` = (state is MEM_RD or MEM_WR) or the MEM pending slot is valid.
  - Both are low in the cycle their done pulse is high.
- Idle RAM bus: `ram_wr_out` = 0, `ram_addr_out` = 0, `ram_dout_out` = 0.
- `ic_inst_out` and `mem_rdata_out` hold their last value until the next completion.

## Timing
- All outputs are registered.
- Reset (`rst_in` = 1 at an edge):
  - State goes to IDLE, `cnt` = 0, both pending slots are cleared.
  - Every output is 0.
  - An in-flight transaction is dropped with no done pulse. A store may have partially written.
- With the request high in cycle 0:
  - read of N bytes: addresses in cycles 1..N, data in cycles 2..N+1, valid pulse in cycle N+2. A word read's valid pulse is in cycle 6; a byte read's is in cycle 3.
  - write of N bytes: writes in cycles 1..N, `mem_done_out` in cycle N+1.
- Back-to-back: the state is IDLE in the completion-pulse cycle. A request present in that cycle, or pending, has its first RAM address in the next cycle.
- Simultaneous `ic_req_in` and `mem_req_in` in IDLE:
  - MEM starts.
  - The IC request is pending and starts in the cycle after MEM completes.
- `rdy_in` = 0:
  - No register changes and no request is sampled; request pulses arriving during this time are lost.
  - The RAM is stalled by the same `rdy_in` at top level.

## Test plan
- Reset, then IC fetch of 0x00104: RAM returns 13,05,00,00 at addresses 0x104..0x107 in cycles 2..5 → `ic_inst_valid_out`=1 in cycle 6 only, `ic_inst_out`=0x00000513, `ic_busy_out` high in cycles 1..5.
- Store word 0xDEADBEEF at 0x1000 → `ram_wr_out`=1 in cycles 1..4; addr/dout pairs (0x1000,EF), (0x1001,BE), (0x1002,AD), (0x1003,DE); `mem_done_out` in cycle 5.
- Byte load from 0x2003 with RAM byte 0x80 → `mem_rdata_out`=0x00000080, `mem_done_out` in cycle 3; half load reads 2 bytes, done in cycle 4.
- `ic_req_in` and `mem_req_in` both in cycle 0 (MEM word load) → MEM done in cycle 6; IC first address in cycle 7, IC valid in cycle 12; `ic_req_in` held high in cycles 1..11 causes no extra fetch.
- Reset asserted in cycle 3 of a word store → cycle 4: all outputs 0, no `mem_done_out`; a new request afterwards completes normally.
- `rdy_in` low in cycles 2..4 during an IC fetch → valid pulse delayed by 3 cycles to cycle 9; data correct.
